mult_ctrl: RTL and testbench

Moore FSM controller for the 32-bit shift-add multiplier datapath. It sits directly upstream of that datapath and drives its init, regWr and shiftR strobes. It consumes the datapath's product LSB and done32 flag, and gives the ALU top level a start/busy/done handshake plus an abort.

---
 rtl/mult_ctrl.sv | 131 +++++++++++++
 tb/tb_mult_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mult_ctrl
//  Purpose  : Moore FSM controller for the 32-bit shift-add multiplier
//             datapath. Drives init/regWr/shiftR toward the datapath and
//             gives the ALU a start/busy/done handshake with abort.
//             DONE_HOLD = 0 : done is a single-cycle pulse.
//             DONE_HOLD = 1 : done is held until the next start or abort.
//             Optional macro MULT_CTRL_CYCLE_CNT_EN adds the cycles[7:0]
//             busy-cycle counter output.
//  Revision : 1.0 - initial release
// ============================================================================
module mult_ctrl #(
    parameter int DONE_HOLD = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       lsb,
    input  logic       done32,
    output logic       init,
    output logic       regWr,
    output logic       shiftR,
    output logic       busy,
    output logic       done
`ifdef MULT_CTRL_CYCLE_CNT_EN
    ,
    output logic [7:0] cycles
`endif
);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_INIT  = 3'd1;
    localparam logic [2:0] c_ST_TEST  = 3'd2;
    localparam logic [2:0] c_ST_ADD   = 3'd3;
    localparam logic [2:0] c_ST_SHIFT = 3'd4;
    localparam logic [2:0] c_ST_DONE  = 3'd5;

    logic [2:0] r_state;
    logic [2:0] w_state_nxt;
    logic       w_busy_nxt;
    logic       r_init;
    logic       r_regwr;
    logic       r_shiftr;
    logic       r_busy;
    logic       r_done;

    // Next-state decode; abort outranks every normal transition while busy.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (start) w_state_nxt = c_ST_INIT;
            end
            c_ST_INIT: begin
                w_state_nxt = abort ? c_ST_IDLE : c_ST_TEST;
            end
            c_ST_TEST: begin
                if (abort)    w_state_nxt = c_ST_IDLE;
                else if (lsb) w_state_nxt = c_ST_ADD;
                else          w_state_nxt = c_ST_SHIFT;
            end
            c_ST_ADD: begin
                w_state_nxt = abort ? c_ST_IDLE : c_ST_SHIFT;
            end
            c_ST_SHIFT: begin
                // done32 high here means this edge performs the 32nd shift
                if (abort)       w_state_nxt = c_ST_IDLE;
                else if (done32) w_state_nxt = c_ST_DONE;
                else             w_state_nxt = c_ST_TEST;
            end
            c_ST_DONE: begin
                if (DONE_HOLD == 0) w_state_nxt = c_ST_IDLE;
                else if (abort)     w_state_nxt = c_ST_IDLE;
                else if (start)     w_state_nxt = c_ST_INIT;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    assign w_busy_nxt = (w_state_nxt == c_ST_INIT) || (w_state_nxt == c_ST_TEST) ||
                        (w_state_nxt == c_ST_ADD)  || (w_state_nxt == c_ST_SHIFT);

    // State register with outputs registered from the next state, so each
    // output is a pure function of the state held in that cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_ST_IDLE;
            r_init   <= 1'b0;
            r_regwr  <= 1'b0;
            r_shiftr <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_init   <= (w_state_nxt == c_ST_INIT);
            r_regwr  <= (w_state_nxt == c_ST_ADD);
            r_shiftr <= (w_state_nxt == c_ST_SHIFT);
            r_busy   <= w_busy_nxt;
            r_done   <= (w_state_nxt == c_ST_DONE);
        end
    end

    assign init   = r_init;
    assign regWr  = r_regwr;
    assign shiftR = r_shiftr;
    assign busy   = r_busy;
    assign done   = r_done;

`ifdef MULT_CTRL_CYCLE_CNT_EN
    logic [7:0] r_cycles;

    // Busy-cycle counter: cleared entering INIT, frozen whenever not busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cycles <= 8'd0;
        end else if (w_state_nxt == c_ST_INIT) begin
            r_cycles <= 8'd0;
        end else if (r_busy) begin
            r_cycles <= r_cycles + 8'd1;
        end
    end

    assign cycles = r_cycles;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mult_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_mult_ctrl
//  Purpose  : Scoreboard bench for mult_ctrl with a behavioural shift-add
//             datapath. One controller instance with DONE_HOLD=0, a second
//             with DONE_HOLD=1.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mult_ctrl;

    logic        clk      = 1'b0;
    logic        rst      = 1'b1;
    logic        start    = 1'b0;
    logic        abort    = 1'b0;
    logic        start_h  = 1'b0;
    logic        abort_h  = 1'b0;
    logic [31:0] r_op_a   = 32'd0;
    logic [31:0] r_op_b   = 32'd0;

    logic w_lsb, w_done32, w_init, w_regwr, w_shiftr, w_busy, w_done;
    logic w_lsb_h, w_done32_h, w_init_h, w_regwr_h, w_shiftr_h, w_busy_h, w_done_h;
`ifdef MULT_CTRL_CYCLE_CNT_EN
    logic [7:0] w_cycles, w_cycles_h;
`endif

    always #5 clk = ~clk;

    mult_ctrl #(.DONE_HOLD(0)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .lsb(w_lsb), .done32(w_done32),
        .init(w_init), .regWr(w_regwr), .shiftR(w_shiftr),
        .busy(w_busy), .done(w_done)
`ifdef MULT_CTRL_CYCLE_CNT_EN
        , .cycles(w_cycles)
`endif
    );

    mult_ctrl #(.DONE_HOLD(1)) dut_h (
        .clk(clk), .rst(rst), .start(start_h), .abort(abort_h),
        .lsb(w_lsb_h), .done32(w_done32_h),
        .init(w_init_h), .regWr(w_regwr_h), .shiftR(w_shiftr_h),
        .busy(w_busy_h), .done(w_done_h)
`ifdef MULT_CTRL_CYCLE_CNT_EN
        , .cycles(w_cycles_h)
`endif
    );

    // Behavioural datapaths: bit 64 holds the adder carry.
    logic [64:0] r_prod   = 65'd0;
    logic [64:0] r_prod_h = 65'd0;
    logic [4:0]  r_cnt    = 5'd0;
    logic [4:0]  r_cnt_h  = 5'd0;

    always @(posedge clk) begin
        if (w_init) begin
            r_cnt  <= 5'd0;
            r_prod <= {33'd0, r_op_b};
        end else if (w_regwr) begin
            r_prod[64:32] <= {1'b0, r_prod[63:32]} + {1'b0, r_op_a};
        end else if (w_shiftr) begin
            r_prod <= r_prod >> 1;
            r_cnt  <= r_cnt + 5'd1;
        end
    end

    always @(posedge clk) begin
        if (w_init_h) begin
            r_cnt_h  <= 5'd0;
            r_prod_h <= {33'd0, r_op_b};
        end else if (w_regwr_h) begin
            r_prod_h[64:32] <= {1'b0, r_prod_h[63:32]} + {1'b0, r_op_a};
        end else if (w_shiftr_h) begin
            r_prod_h <= r_prod_h >> 1;
            r_cnt_h  <= r_cnt_h + 5'd1;
        end
    end

    assign w_lsb      = r_prod[0];
    assign w_done32   = (r_cnt == 5'd31);
    assign w_lsb_h    = r_prod_h[0];
    assign w_done32_h = (r_cnt_h == 5'd31);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] prod;
        int          lat;
        int          regwr;
        int          busy;
    } exp_t;

    exp_t sb[$];
    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: gathers per-multiply statistics and checks them on done.
    initial begin : mon
        exp_t e;
        logic p_init  = 1'b0;
        logic p_regwr = 1'b0;
        logic p_done  = 1'b0;
        logic chk_fall = 1'b0;
        int t0 = 0, c_regwr = 0, c_shift = 0, c_busy = 0, c_init = 0, c_viol = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (chk_fall) begin
                    chk("done_one_cycle", {63'd0, w_done}, 64'd0);
                    chk_fall = 1'b0;
                end
                if (w_init && !p_init) begin
                    t0 = cyc; c_regwr = 0; c_shift = 0; c_busy = 0; c_init = 0; c_viol = 0;
                end
                if (w_init)   c_init++;
                if (w_regwr)  c_regwr++;
                if (w_shiftr) c_shift++;
                if (w_busy)   c_busy++;
                if (int'(w_init) + int'(w_regwr) + int'(w_shiftr) > 1) c_viol++;
                if (p_regwr && !w_shiftr) c_viol++;
                if (w_done && !p_done) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_done", 64'd1, 64'd0);
                    end else begin
                        e = sb.pop_front();
                        chk("product",     r_prod[63:0],        e.prod);
                        chk("done_latency", 64'(cyc - t0 + 1),  64'(e.lat));
                        chk("regwr_count", 64'(c_regwr),        64'(e.regwr));
                        chk("shift_count", 64'(c_shift),        64'd32);
                        chk("busy_count",  64'(c_busy),         64'(e.busy));
                        chk("init_count",  64'(c_init),         64'd1);
                        chk("strobe_rule", 64'(c_viol),         64'd0);
`ifdef MULT_CTRL_CYCLE_CNT_EN
                        chk("cycles_reg",  64'(w_cycles),       64'(e.busy));
`endif
                        chk_fall = 1'b1;
                    end
                end
            end
            p_init  = w_init;
            p_regwr = w_regwr;
            p_done  = w_done;
        end
    end

    task automatic wait_done(input int budget);
        int k = 0;
        while (!w_done && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (!w_done) chk("done_timeout", 64'd0, 64'd1);
        @(negedge clk);
    endtask

    task automatic run_one(input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] prod, input int lat, input int regwr);
        @(negedge clk);
        r_op_a = a;
        r_op_b = b;
        start  = 1'b1;
        sb.push_back('{prod, lat, regwr, lat - 1});
        @(negedge clk);
        start = 1'b0;
        wait_done(150);
    endtask

    // Directed stimulus.
    initial begin : stim
        int held, dcnt;
        repeat (2) @(negedge clk);
        chk("reset_outs",   {59'd0, w_init, w_regwr, w_shiftr, w_busy, w_done}, 64'd0);
        chk("reset_outs_h", {59'd0, w_init_h, w_regwr_h, w_shiftr_h, w_busy_h, w_done_h}, 64'd0);
        rst = 1'b0;

        run_one(32'h1234_5678, 32'd5,         64'h0000_0000_5B05_B058, 68, 2);
        run_one(32'hDEAD_BEEF, 32'd0,         64'h0,                   66, 0);
        run_one(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 98, 32);

        // Abort on the 10th busy cycle.
        @(negedge clk);
        r_op_a = 32'h0000_AAAA;
        r_op_b = 32'h0000_FFFF;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        chk("abort_pre_busy", {63'd0, w_busy}, 64'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy_low", {62'd0, w_busy, w_done}, 64'd0);
`ifdef MULT_CTRL_CYCLE_CNT_EN
        chk("abort_cycles_frozen", 64'(w_cycles), 64'd10);
`endif
        dcnt = 0;
        repeat (80) begin
            @(negedge clk);
            if (w_done || w_busy) dcnt++;
        end
        chk("abort_no_done", 64'(dcnt), 64'd0);
        run_one(32'h0000_1001, 32'd3, 64'h3003, 68, 2);

        // Reset pulse while in ADD.
        @(negedge clk);
        r_op_a = 32'd5;
        r_op_b = 32'd1;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("in_add_state", {63'd0, w_regwr}, 64'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_outs", {59'd0, w_init, w_regwr, w_shiftr, w_busy, w_done}, 64'd0);
        rst = 1'b0;
        run_one(32'd7, 32'd9, 64'h3F, 68, 2);

        // Start held high: back-to-back multiplies with one IDLE cycle.
        @(negedge clk);
        r_op_a = 32'd3;
        r_op_b = 32'd2;
        start  = 1'b1;
        sb.push_back('{64'd6, 67, 1, 66});
        sb.push_back('{64'd6, 67, 1, 66});
        wait_done(150);
        chk("b2b_idle_gap", {62'd0, w_init, w_busy}, 64'd0);
        @(negedge clk);
        chk("b2b_restart", {63'd0, w_init}, 64'd1);
        start = 1'b0;
        wait_done(150);
        repeat (2) @(negedge clk);

        // DONE_HOLD=1 instance.
        r_op_a  = 32'h0000_00FF;
        r_op_b  = 32'd1;
        start_h = 1'b1;
        @(negedge clk);
        start_h = 1'b0;
        dcnt = 0;
        while (!w_done_h && dcnt < 150) begin
            @(negedge clk);
            dcnt++;
        end
        chk("hold_product", r_prod_h[63:0], 64'hFF);
        held = 0;
        repeat (20) begin
            @(negedge clk);
            if (w_done_h) held++;
        end
        chk("hold_done_held", 64'(held), 64'd20);
        start_h = 1'b1;
        @(negedge clk);
        start_h = 1'b0;
        chk("hold_restart", {62'd0, w_done_h, w_init_h}, 64'd1);
        dcnt = 0;
        while (!w_done_h && dcnt < 150) begin
            @(negedge clk);
            dcnt++;
        end
        chk("hold_second_done", {63'd0, w_done_h}, 64'd1);
        abort_h = 1'b1;
        @(negedge clk);
        abort_h = 1'b0;
        chk("hold_abort_clears", {62'd0, w_done_h, w_busy_h}, 64'd0);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
